// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Shares a single cordic core between NREQ requesters. A round-robin scan
// picks the next requester and the arbiter loads its angle into the core and
// pulses core_start. It then waits for core_done and hands the results back
// to that requester. A watchdog aborts the operation if the core never
// answers. The abort is reported with rsp_err=1 and all-zero results.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        angle / result width
//   TIMEOUT  maximum WAIT cycles before abort (>= 2)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req/req_angle/req_radian   per-requester request level, angle, radian_en
//   gnt                 one-hot pulse: request accepted
//   rsp_valid           one-hot pulse: results valid for that requester
//   rsp_sin/cos/tan/cot shared result bus, held between responses
//   rsp_err             qualifies rsp_valid: 1 = timeout abort
//   busy                high whenever the arbiter is not idle
//   core_start          one-cycle start pulse to the core
//   core_angle/core_radian_en  operands to the core, held from grant to grant
//   core_sin/cos/tan/cot, core_done  core results and completion
//
// Optional build macro
//   CORDIC_ARB_STATS_EN adds saturating counters stat_ops and stat_timeouts.
// -----------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_angle,
    input  logic [NREQ-1:0]   req_radian,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sin,
    output logic [W-1:0]      rsp_cos,
    output logic [W-1:0]      rsp_tan,
    output logic [W-1:0]      rsp_cot,
    output logic              rsp_err,
    output logic              busy,
`ifdef CORDIC_ARB_STATS_EN
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_timeouts,
`endif
    output logic              core_start,
    output logic [W-1:0]      core_angle,
    output logic              core_radian_en,
    input  logic [W-1:0]      core_sin,
    input  logic [W-1:0]      core_cos,
    input  logic [W-1:0]      core_tan,
    input  logic [W-1:0]      core_cot,
    input  logic              core_done
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   ptr;        // round-robin start point for the next scan
    logic [PW-1:0]   win_q;      // requester owning the operation in flight
    logic [CW-1:0]   cnt;        // WAIT cycles elapsed for this operation

    logic            found;
    logic [PW-1:0]   winner;
    logic [PW:0]     scan_sum;
    logic [PW-1:0]   scan_idx;

    logic            grant_fire;
    logic            done_take;
    logic            tmo_hit;

    // -------------------------------------------------------------------------
    // Round-robin scan. Candidates are visited from the farthest offset down
    // to offset 0, so the nearest set request (from ptr, upward with wrap)
    // is the last one written and wins.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state. The first WAIT cycle (cnt == 0) ignores core_done so
    // that a done left over from the previous operation is not taken. A done
    // in the same cycle as expiry takes priority over the abort.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        done_take  = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_fire = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((cnt != '0) && core_done) begin
                    done_take = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // Datapath. Pulses (gnt, core_start, rsp_valid) default low each cycle.
    // Operands and results otherwise hold their values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this design has no memories, so every register is cleared by
        // reset. That includes the operand and result buses, which must read
        // 0 out of reset.
        if (rst) begin
            gnt            <= '0;
            rsp_valid      <= '0;
            rsp_sin        <= '0;
            rsp_cos        <= '0;
            rsp_tan        <= '0;
            rsp_cot        <= '0;
            rsp_err        <= 1'b0;
            core_start     <= 1'b0;
            core_angle     <= '0;
            core_radian_en <= 1'b0;
            ptr            <= '0;
            win_q          <= '0;
            cnt            <= '0;
        end else begin
            gnt        <= '0;
            core_start <= 1'b0;
            rsp_valid  <= '0;

            if (grant_fire) begin
                gnt            <= NREQ'(1) << winner;
                core_start     <= 1'b1;
                core_angle     <= req_angle[int'(winner)*W +: W];
                core_radian_en <= req_radian[winner];
                win_q          <= winner;
                cnt            <= '0;
                ptr            <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
            end

            if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end

            if (done_take) begin
                rsp_sin   <= core_sin;
                rsp_cos   <= core_cos;
                rsp_tan   <= core_tan;
                rsp_cot   <= core_cot;
                rsp_err   <= 1'b0;
                rsp_valid <= NREQ'(1) << win_q;
            end else if (tmo_hit) begin
                rsp_sin   <= '0;
                rsp_cos   <= '0;
                rsp_tan   <= '0;
                rsp_cot   <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= NREQ'(1) << win_q;
            end

            // The error flag only qualifies the single RESP cycle.
            if (state == S_RESP) begin
                rsp_err <= 1'b0;
            end
        end
    end

`ifdef CORDIC_ARB_STATS_EN
    // Saturating operation / abort counters, bumped once per RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops      <= '0;
            stat_timeouts <= '0;
        end else if (state == S_RESP) begin
            if (stat_ops != 16'hFFFF) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (rsp_err && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`else
`endif

endmodule
